if_prefetch_queue: RTL and testbench

//   Instruction-fetch stage between the combinational imem and the decode stage of cpu_top.
//   - Owns the fetch PC and drives the imem address.
//   - Captures each returned word with its PC into a small FIFO.
//   - Hands {pc, inst} to decode over a valid/ready handshake.
//   - Flushes the FIFO and restarts fetch on a branch/jump redirect from EX.
//

---
 rtl/if_prefetch_queue_pkg.sv | 23 ++
 rtl/if_prefetch_queue_if.sv | 21 ++
 rtl/if_prefetch_queue_fifo.sv | 76 +++++++
 rtl/if_prefetch_queue.sv | 80 ++++++++
 tb/tb_if_prefetch_queue.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue_pkg
//   Shared RV32I fetch-side constants and types, used by cpu_top and by the
//   instruction-fetch prefetch queue.
//   XLEN             datapath width
//   INST_NOP         canonical NOP (addi x0, x0, 0) shown when nothing is valid
//   PC_STEP          sequential fetch increment
//   RESET_PC_DEFAULT fetch PC loaded on reset
//   fetch_entry_t    one queue entry: {pc, inst}
// ---------------------------------------------------------------------------
package if_prefetch_queue_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue_if
//   Fetch -> decode handshake.
//   if_valid  head entry valid
//   if_pc     PC of head entry (0 when not valid)
//   if_inst   instruction of head entry (NOP when not valid)
//   id_ready  decode accepts the head entry this cycle
//   master = fetch side, slave = decode side.
// ---------------------------------------------------------------------------
interface if_prefetch_queue_if;
  import if_prefetch_queue_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            id_ready;

  modport master (output if_valid, output if_pc, output if_inst, input id_ready);
  modport slave  (input if_valid, input if_pc, input if_inst, output id_ready);

endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo
//   Small register-array FIFO with synchronous flush.
//   clk, rst   clock / asynchronous active-low reset
//   i_push     write i_din at the tail (ignored when full unless popping)
//   i_pop      drop the head entry (ignored when empty)
//   i_flush    empty the queue; wins over push and pop
//   i_din      write data
//   o_dout     head entry (storage contents when empty are don't-care)
//   o_empty    no entries
//   o_full     DEPTH entries
// ---------------------------------------------------------------------------
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = PW + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);
  assign o_dout  = r_mem[r_rptr];

  // A full queue can still accept a write when the head leaves in the same
  // cycle: the slot being written is the one being read out.
  assign w_rd = i_pop & ~o_empty & ~i_flush;
  assign w_wr = i_push & ~i_flush & (~o_full | w_rd);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by r_count alone, so
  // stale contents are never observed and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction-fetch stage: owns the fetch PC, drives the combinational imem,
//   queues {pc, inst} pairs and hands them to decode; a redirect flushes the
//   queue and restarts fetch at the target.
//   clk, rst        clock / asynchronous active-low reset
//   inst_addr_o     imem address (= fetch PC)
//   inst_i          imem data for inst_addr_o, same cycle
//   redirect_i      flush and restart fetch
//   redirect_pc_i   restart target, bits [1:0] forced to 0
//   id_bus          decode handshake (master side)
// ---------------------------------------------------------------------------
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [XLEN-1:0]      inst_addr_o,
  input  logic [XLEN-1:0]      inst_i,
  input  logic                 redirect_i,
  input  logic [XLEN-1:0]      redirect_pc_i,
  if_prefetch_queue_if.master  id_bus
);

  logic [XLEN-1:0] r_fetch_pc;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_valid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_tail;
  logic            w_unused_pc_lsb;

  // Target alignment drops the low bits; keep them visibly consumed.
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  assign w_valid = ~w_empty;
  assign w_pop   = w_valid & id_bus.id_ready;
  // Redirect squashes the word fetched this cycle; a full queue may still
  // take a word when its head is popped, sustaining one per cycle.
  assign w_push  = ~redirect_i & (~w_full | w_pop);

  assign w_tail      = '{pc: r_fetch_pc, inst: inst_i};
  assign inst_addr_o = r_fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_din   (w_tail),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Idle values are fixed so decode never sees stale storage.
  assign id_bus.if_valid = w_valid;
  assign id_bus.if_pc    = w_valid ? w_head.pc   : '0;
  assign id_bus.if_inst  = w_valid ? w_head.inst : INST_NOP;

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int              DEPTH    = 4;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;

  if_prefetch_queue_if id_bus ();

  if_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_addr_o   (inst_addr),
    .inst_i        (inst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_bus        (id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational imem: distinct word per address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction
  assign inst = imem_word(inst_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, inst} and the next PC to fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
  entry_t      m_q[$];
  logic [31:0] m_pc;

  task automatic model_reset();
    m_q.delete();
    m_pc = RESET_PC;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".addr"},  inst_addr, m_pc);
    check({ctx, ".valid"}, {31'd0, id_bus.if_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      check({ctx, ".pc"},   id_bus.if_pc,   m_q[0].pc);
      check({ctx, ".inst"}, id_bus.if_inst, m_q[0].inst);
    end else begin
      check({ctx, ".pc_idle"},   id_bus.if_pc,   32'h0);
      check({ctx, ".inst_idle"}, id_bus.if_inst, INST_NOP);
    end
  endtask

  // One cycle, entered and left at a negedge: check state, drive inputs,
  // advance the model by the same rules, let the clock edge happen.
  task automatic cycle(input string ctx, input bit rdy, input bit rd, input logic [31:0] rpc);
    bit pop;
    check_outputs(ctx);
    id_bus.id_ready = rdy;
    redirect        = rd;
    redirect_pc     = rpc;
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (rd) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (m_q.size() < DEPTH) begin
      m_q.push_back('{pc: m_pc, inst: imem_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    id_bus.id_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.addr",  inst_addr, RESET_PC);
    check("rst.valid", {31'd0, id_bus.if_valid}, 32'd0);
    check("rst.pc",    id_bus.if_pc, 32'd0);
    check("rst.inst",  id_bus.if_inst, INST_NOP);
    rst = 1'b1;
  endtask

  // Structural checks on internal state.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(dut.w_pop && !dut.w_valid)) else $error("pop while not valid");
      assert (int'(dut.u_fifo.r_count) <= DEPTH) else $error("count exceeds DEPTH");
    end
  end

  initial begin
    rst = 1'b0;
    id_bus.id_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    @(negedge clk);

    // 1: reset then streaming
    do_reset();
    repeat (8) cycle("t1", 1'b1, 1'b0, '0);

    // 2: backpressure, then release
    do_reset();
    repeat (10) cycle("t2", 1'b0, 1'b0, '0);
    check("t2.frozen_pc", inst_addr, 32'd16);
    check("t2.head_pc",   id_bus.if_pc, 32'd0);
    repeat (10) cycle("t2r", 1'b1, 1'b0, '0);

    // 3: redirect with three entries queued
    do_reset();
    repeat (3) cycle("t3", 1'b0, 1'b0, '0);
    cycle("t3", 1'b0, 1'b1, 32'h100);
    check("t3.valid0", {31'd0, id_bus.if_valid}, 32'd0);
    check("t3.addr",   inst_addr, 32'h100);
    cycle("t3", 1'b1, 1'b0, '0);
    check("t3.head", id_bus.if_pc, 32'h100);
    repeat (4) cycle("t3", 1'b1, 1'b0, '0);

    // 4: misaligned target with wrap
    cycle("t4", 1'b1, 1'b1, 32'hFFFF_FFFE);
    check("t4.addr", inst_addr, 32'hFFFF_FFFC);
    cycle("t4", 1'b1, 1'b0, '0);
    check("t4.wrap", inst_addr, 32'h0);
    repeat (4) cycle("t4", 1'b1, 1'b0, '0);

    // 5: redirect on a full queue while decode pops
    repeat (6) cycle("t5", 1'b0, 1'b0, '0);
    check("t5.full", {29'd0, dut.u_fifo.r_count}, DEPTH);
    cycle("t5", 1'b1, 1'b1, 32'h0000_2040);
    check("t5.count", {29'd0, dut.u_fifo.r_count}, 32'd0);
    repeat (3) cycle("t5", 1'b1, 1'b0, '0);

    // 6: asynchronous reset between edges
    repeat (3) cycle("t6", 1'b0, 1'b0, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6.valid", {31'd0, id_bus.if_valid}, 32'd0);
    check("t6.addr",  inst_addr, RESET_PC);
    check("t6.inst",  id_bus.if_inst, INST_NOP);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit          rdy;
      bit          rd;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      cycle("rnd", rdy, rd, tgt);
    end
    check_outputs("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
